// File: rtl/neuron_pkg.sv
// neuron_pkg: shared Q8.8 types, FSM states and saturation helpers for the neuron datapath
package neuron_pkg;
  localparam int DATA_W = 17;
  localparam int ACC_W = 24;
  localparam int FRAC_BITS = 8;
  localparam logic [DATA_W-1:0] ONE = 17'h00100;
  typedef logic signed [DATA_W-1:0] q88_t;
  typedef enum logic [1:0] {ACCUM, DRAIN, COMMIT} state_e;
  // clamp a wide signed value into a w-bit signed range
  function automatic logic signed [47:0] sat_w(input logic signed [47:0] x, input int w);
    logic signed [47:0] hi;
    hi = (48'sd1 <<< (w - 1)) - 48'sd1;
    return x > hi ? hi : x < -hi - 48'sd1 ? -hi - 48'sd1 : x;
  endfunction
  function automatic q88_t sat_data(input logic signed [47:0] x);
    return q88_t'(sat_w(x, DATA_W));
  endfunction
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [47:0] x);
    return ACC_W'(sat_w(x, ACC_W));
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous power-of-2 FIFO with occupancy count; push on full and pop on empty are ignored
module event_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_comb begin
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/synaptic_current_integrator.sv
// synaptic_current_integrator: accumulates weighted spike events plus bias into the per-timestep
// current for state_update.i_in, with exponential decay of the accumulator after each commit.
module synaptic_current_integrator #(
  parameter int DATA_W      = 17,
  parameter int ACC_W       = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int DECAY_SHIFT = 2
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic              step_tick,
  input  logic              evt_valid,
  output logic              evt_ready,
  input  logic [DATA_W-1:0] evt_weight,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] i_out,
  output logic              i_valid,
  output logic              busy,
  output logic              tick_overrun
);
  import neuron_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [CW-1:0] drain_q, drain_d, count, pre_drain;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] i_out_q, i_out_d, fifo_dout;
  logic i_valid_q, ovr_q, full, empty, push, pop;
  assign evt_ready = !full;
  assign push = evt_valid & !full;
  assign pop = !empty & (state_q == ACCUM || (state_q == DRAIN && drain_q != '0));
  assign busy = state_q != ACCUM;
  assign i_out = i_out_q;
  assign i_valid = i_valid_q;
  assign tick_overrun = ovr_q;
  // entries already queued at the tick, excluding the one popped in that same cycle
  assign pre_drain = count - CW'(pop);
  event_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(asyn_reset), .push(push), .pop(pop), .din(evt_weight),
    .dout(fifo_dout), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    acc_d = pop ? ACC_W'(sat_w(48'(acc_q) + 48'(signed'(fifo_dout)), ACC_W)) : acc_q;
    state_d = state_q;
    drain_d = drain_q;
    i_out_d = i_out_q;
    if (state_q == ACCUM && step_tick) begin
      drain_d = pre_drain;
      state_d = pre_drain != '0 ? DRAIN : COMMIT;
    end
    if (state_q == DRAIN) begin
      drain_d = drain_q - CW'(pop);
      state_d = drain_q <= CW'(1) ? COMMIT : DRAIN;
    end
    if (state_q == COMMIT) begin
      i_out_d = DATA_W'(sat_w(48'(acc_q) + 48'(signed'(bias)), DATA_W));
      acc_d = acc_q - (acc_q >>> DECAY_SHIFT);
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk or negedge asyn_reset)
    if (!asyn_reset) begin
      state_q <= ACCUM;
      drain_q <= '0;
      acc_q <= '0;
      i_out_q <= '0;
      i_valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      acc_q <= acc_d;
      i_out_q <= i_out_d;
      i_valid_q <= state_q == COMMIT;
      ovr_q <= step_tick & busy;
    end
endmodule

// File: tb/tb_synaptic_current_integrator.sv
// tb_synaptic_current_integrator: scoreboard bench; a second instance with DECAY_SHIFT=0 shares all inputs
module tb_synaptic_current_integrator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_tick = 1'b0;
  logic evt_valid = 1'b0;
  logic [16:0] evt_weight = '0;
  logic [16:0] bias = '0;
  logic evt_ready, i_valid, busy, tick_overrun;
  logic [16:0] i_out;
  logic evt_ready0, i_valid0, busy0, tick_overrun0;
  logic [16:0] i_out0;
  int n_chk = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int valid0_cnt = 0;
  int ov_cnt = 0;
  longint sum0 = 0;
  logic [16:0] last0 = '0;
  logic [16:0] exp_q[$];
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  synaptic_current_integrator #(.DECAY_SHIFT(2)) dut (
    .clk(clk), .asyn_reset(rst_n), .step_tick(step_tick), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_weight(evt_weight), .bias(bias), .i_out(i_out),
    .i_valid(i_valid), .busy(busy), .tick_overrun(tick_overrun)
  );

  synaptic_current_integrator #(.DECAY_SHIFT(0)) dut0 (
    .clk(clk), .asyn_reset(rst_n), .step_tick(step_tick), .evt_valid(evt_valid),
    .evt_ready(evt_ready0), .evt_weight(evt_weight), .bias(bias), .i_out(i_out0),
    .i_valid(i_valid0), .busy(busy0), .tick_overrun(tick_overrun0)
  );

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (i_valid) begin
        valid_cnt++;
        if (chk_en) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_i_valid: got i_out=%h, expected no output", i_out);
          end else begin
            e = exp_q.pop_front();
            if (i_out !== e) begin
              n_fail++;
              $display("FAIL i_out: got %h, expected %h", i_out, e);
            end
          end
        end
      end
      if (tick_overrun) ov_cnt++;
      if (i_valid0) begin
        valid0_cnt++;
        sum0 += longint'(signed'(i_out0));
        last0 = i_out0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_n(input logic [16:0] w, input int n);
    evt_valid = 1'b1;
    evt_weight = w;
    repeat (n) step();
    evt_valid = 1'b0;
  endtask

  task automatic wait_valid(input int v0, input string name);
    for (int i = 0; i < 40 && valid_cnt == v0; i++) step();
    n_chk++;
    if (valid_cnt == v0) begin
      n_fail++;
      $display("FAIL %s_timeout: got no i_valid in 40 cycles, expected one", name);
    end
  endtask

  task automatic tick_expect(input logic [16:0] e, input bit chk_lat, input string name);
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(e);
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    step();
    if (chk_lat) begin
      n_chk++;
      if (i_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_latency: got i_valid=%b at T+2, expected 1", name, i_valid);
      end
    end
    wait_valid(v0, name);
  endtask

  task automatic test_reset();
    bias = 17'h00123;
    do_reset();
    push_n(17'h00100, 3);
    evt_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    n_chk += 4;
    if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", evt_ready); end
    if (i_out !== 17'h0) begin n_fail++; $display("FAIL rst_i_out: got %h, expected 0", i_out); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    if (i_valid !== 1'b0) begin n_fail++; $display("FAIL rst_i_valid: got %b, expected 0", i_valid); end
    evt_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_chk++;
    if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b, expected 1", evt_ready); end
    tick_expect(17'h00123, 1'b1, "rst_first_tick");
  endtask

  task automatic test_basic_sum();
    bias = 17'h0;
    do_reset();
    push_n(17'h00400, 1);
    push_n(17'h00200, 1);
    repeat (3) step();
    tick_expect(17'h00600, 1'b1, "sum");
    n_chk++;
    if (last0 !== 17'h00600) begin n_fail++; $display("FAIL sum_nodecay: got %h, expected 00600", last0); end
    repeat (3) step();
    tick_expect(17'h00480, 1'b0, "decay");
    n_chk++;
    if (last0 !== 17'h0) begin n_fail++; $display("FAIL full_clear: got %h, expected 00000", last0); end
  endtask

  task automatic test_back_to_back();
    int v0;
    bias = 17'h0;
    do_reset();
    v0 = valid_cnt;
    exp_q.push_back(17'h00300);
    evt_weight = 17'h00100;
    for (int i = 0; i < 4; i++) begin
      evt_valid = 1'b1;
      step_tick = (i == 3);
      step();
    end
    evt_valid = 1'b0;
    step_tick = 1'b0;
    step();
    n_chk++;
    if (i_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: got i_valid=%b, expected 1", i_valid); end
    wait_valid(v0, "b2b");
    repeat (3) step();
    tick_expect(17'h00340, 1'b0, "b2b_next_step");
  endtask

  task automatic test_saturation();
    do_reset();
    bias = 17'h0FF00;
    push_n(17'h0FFFF, 40);
    repeat (4) step();
    tick_expect(17'h0FFFF, 1'b0, "sat_pos");
    bias = 17'h10000;
    push_n(17'h10001, 40);
    repeat (4) step();
    tick_expect(17'h10000, 1'b0, "sat_neg");
    bias = 17'h0;
    do_reset();
    push_n(17'h0FFFF, 130);
    push_n(17'h10001, 128);
    repeat (4) step();
    tick_expect(17'h0007F, 1'b0, "sat_acc");
    n_chk++;
    if (last0 !== 17'h0007F) begin n_fail++; $display("FAIL sat_acc_nodecay: got %h, expected 0007f", last0); end
  endtask

  task automatic test_overrun();
    int v0, o0;
    bias = 17'h0;
    do_reset();
    chk_en = 1'b0;
    evt_weight = 17'h00010;
    evt_valid = 1'b1;
    step_tick = 1'b1;
    step();
    step_tick = 1'b0;
    step();
    step();
    v0 = valid_cnt;
    o0 = ov_cnt;
    step_tick = 1'b1;
    step();
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b, expected 1", busy); end
    step();
    step_tick = 1'b0;
    evt_valid = 1'b0;
    repeat (8) step();
    n_chk += 2;
    if (ov_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d, expected 1", ov_cnt - o0); end
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL ovr_valids: got %0d, expected 1", valid_cnt - v0); end
  endtask

  task automatic test_backpressure();
    int accepted;
    bit saw_full;
    bias = 17'h0;
    do_reset();
    chk_en = 1'b0;
    sum0 = 0;
    accepted = 0;
    saw_full = 1'b0;
    evt_weight = 17'h00010;
    for (int i = 0; i < 60; i++) begin
      evt_valid = 1'b1;
      step_tick = (i % 4 == 0);
      if (evt_ready) accepted++;
      else saw_full = 1'b1;
      step();
    end
    evt_valid = 1'b0;
    step_tick = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 2; k++) begin
      step_tick = 1'b1;
      step();
      step_tick = 1'b0;
      repeat (8) step();
    end
    n_chk += 2;
    if (!saw_full) begin n_fail++; $display("FAIL bp_full: got evt_ready never low, expected backpressure"); end
    if (sum0 != longint'(accepted) * 16) begin
      n_fail++;
      $display("FAIL bp_sum: got %0d, expected %0d", sum0, longint'(accepted) * 16);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_back_to_back();
    test_saturation();
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending: got %0d outstanding, expected 0", exp_q.size()); end
    test_overrun();
    test_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
